hpi_bus_sequencer: RTL and testbench
====================================

# hpi_bus_sequencer

Sequences and shares the 4-register HPI port of the USB controller between two requesters: port A (software bridge) and port B (hardware poller). It sits directly upstream of the HPI pin-interface block, driving that block's address, data, read, write and chip-select inputs with a timed setup/strobe/hold/recovery cycle. It returns read data with a one-cycle acknowledge. Both directions through the pin-interface are registered, adding one cycle each way, and the strobe length covers that delay.

## Interface
- SETUP_CYCLES, 1: cycles CS is low with address valid before the strobe; min 1.
- STROBE_CYCLES, 4: cycles the RD/WR strobe is low; min 3, covering the 2-cycle registered round trip plus access time.
- RECOVERY_CYCLES, 2: cycles CS is high after each transaction before the next grant; min 1.

- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- a_req / b_req  in  1  request, held high until the matching ack.
- a_we / b_we  in  1  1 = write, 0 = read; sampled at grant.
- a_addr / b_addr  in  2  HPI register select; sampled at grant.
- a_wdata / b_wdata  in  16  write data; sampled at grant.
- a_ack / b_ack  out  1  one-cycle completion pulse.
- a_rdata / b_rdata  out  16  read data; valid in the ack cycle and held until the next ack on that port.
- busy  out  1  high in every state except IDLE.
- hpi_address  out  2  to the pin-interface address input.
- hpi_data_out  out  16  to the pin-interface write-data input.
- hpi_data_in  in  16  from the pin-interface read-data output.
- hpi_r_n / hpi_w_n / hpi_cs_n  out  1  active-low strobes to the pin-interface.

## Operation
- Reset values: hpi_cs_n = hpi_r_n = hpi_w_n = 1, hpi_address = 0, hpi_data_out = 0, acks 0, rdata 0, busy 0, state IDLE, last-grant = B (so A wins first).
- States: IDLE, SETUP, STROBE, HOLD, RECOVER.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port not granted last (round-robin).
  - At grant, latch port id, we, addr and wdata, then go to SETUP.
- SETUP:
  - hpi_cs_n = 0, hpi_address = latched address.
  - hpi_data_out = latched wdata if write, else 0.
  - Lasts SETUP_CYCLES cycles, then go to STROBE.
- STROBE:
  - As SETUP, plus hpi_w_n = 0 (write) or hpi_r_n = 0 (read).
  - Never assert both strobes.
  - hpi_w_n stays 1 for the whole of a read so the pin-interface tristates the bus.
  - Lasts STROBE_CYCLES cycles.
  - Read: capture hpi_data_in into the granted port's rdata on the final STROBE cycle.
- HOLD: exactly 1 cycle.
  - Strobes 1; hpi_cs_n, address and data unchanged.
  - Pulse the granted port's ack.
- RECOVER:
  - hpi_cs_n = 1; address and data hold their values.
  - Lasts RECOVERY_CYCLES cycles, then return to IDLE.
- Phase counter is $clog2(max parameter + 1) bits; it reloads on every state entry and never wraps.
- Dropping req mid-transaction does not abort it; the ack still pulses and the requester ignores it.
- The ungranted port's ack and rdata do not change.
- Reset asserted mid-transaction: all strobes go high immediately (asynchronously) and the transaction is lost without an ack.

## Timing
- Grant-to-ack latency: SETUP_CYCLES + STROBE_CYCLES + 1 cycles after leaving IDLE. With defaults: grant at cycle 0 (IDLE), ack in cycle 6.
- Ack-to-next-grant: RECOVERY_CYCLES + 1 cycles.
- Back-to-back period with defaults: 1 + 1 + 4 + 1 + 2 = 9 cycles per transaction.
- A request rising while busy waits; arbitration happens only in IDLE.
- A requester may deassert req the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- All outputs are registered; no combinational path from req to the hpi_* outputs.

## Test plan
- Reset low mid-STROBE of a write: hpi_w_n and hpi_cs_n go to 1 before the next Clk edge; no ack; after release, state is IDLE and busy = 0.
- A write, addr 2, data 0x1234:
  - hpi_cs_n low for 6 cycles.
  - hpi_w_n low for exactly 4 cycles with hpi_data_out = 0x1234 and hpi_address = 2.
  - hpi_r_n stays 1; a_ack pulses once in cycle 6 after grant.
- B read, addr 0; model returns 0xBEEF two cycles after hpi_r_n falls:
  - hpi_w_n stays 1 throughout.
  - b_rdata = 0xBEEF at the b_ack pulse; a_rdata unchanged.
- Both req high continuously for 4 transactions: grants alternate A, B, A, B, with acks 9 cycles apart.
- A drops req during SETUP: the transaction completes; a_ack still pulses; next IDLE with no req stays idle with busy = 0.
- Parameters SETUP=2, STROBE=3, RECOVERY=1: strobe low for exactly 3 cycles; grant-to-ack 6 cycles; back-to-back period 8 cycles.

Source files
------------

// File: rtl/hpi_bus_sequencer.sv
// Two-port arbiter and cycle sequencer for the USB controller's 4-register HPI port.
// Produces timed CS/strobe cycles into the registered pin-interface block.
`timescale 1ns/1ps
module hpi_bus_sequencer #(
   parameter int SETUP_CYCLES    = 1,
   parameter int STROBE_CYCLES   = 4,
   parameter int RECOVERY_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [1:0]  a_addr,
   input  logic [15:0] a_wdata,
   output logic        a_ack,
   output logic [15:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [1:0]  b_addr,
   input  logic [15:0] b_wdata,
   output logic        b_ack,
   output logic [15:0] b_rdata,
   output logic        busy,
   output logic [1:0]  hpi_address,
   output logic [15:0] hpi_data_out,
   input  logic [15:0] hpi_data_in,
   output logic        hpi_r_n,
   output logic        hpi_w_n,
   output logic        hpi_cs_n
);

   localparam int MAXP = (SETUP_CYCLES > STROBE_CYCLES)
                         ? ((SETUP_CYCLES > RECOVERY_CYCLES) ? SETUP_CYCLES : RECOVERY_CYCLES)
                         : ((STROBE_CYCLES > RECOVERY_CYCLES) ? STROBE_CYCLES : RECOVERY_CYCLES);
   localparam int CW = $clog2(MAXP + 1);

   localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] RECOV_LD  = CW'(RECOVERY_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

   typedef struct packed {
      logic        port;   // 0 = A, 1 = B
      logic        we;
      logic [1:0]  addr;
      logic [15:0] wdata;
   } xact_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   xact_t         xact_q, xact_d;
   logic          last_q, last_d;
   logic          gnt_b;

   logic          cs_d, r_d, w_d, ack_a_d, ack_b_d, busy_d, cap;
   logic [1:0]    addr_d;
   logic [15:0]   data_d;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         xact_q  <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         xact_q  <= xact_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      xact_d  = xact_q;
      last_d  = last_q;
      gnt_b   = 1'b0;
      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               // on contention, the port not served last wins
               gnt_b   = b_req && (!a_req || !last_q);
               xact_d  = gnt_b ? xact_t'{1'b1, b_we, b_addr, b_wdata}
                               : xact_t'{1'b0, a_we, a_addr, a_wdata};
               last_d  = gnt_b;
               state_d = SETUP;
               cnt_d   = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = STROBE;
               cnt_d   = STROBE_LD;
            end else cnt_d = cnt_q - CW'(1);
         end
         STROBE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else cnt_d = cnt_q - CW'(1);
         end
         HOLD: begin
            state_d = RECOVER;
            cnt_d   = RECOV_LD;
         end
         RECOVER: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else cnt_d = cnt_q - CW'(1);
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output registers follow the next state so each pin level lines up with its state cycle
   always_comb begin
      cs_d    = !(state_d == SETUP || state_d == STROBE || state_d == HOLD);
      w_d     = !(state_d == STROBE && xact_d.we);
      r_d     = !(state_d == STROBE && !xact_d.we);
      addr_d  = hpi_address;
      data_d  = hpi_data_out;
      if (state_d == SETUP) begin
         addr_d = xact_d.addr;
         data_d = xact_d.we ? xact_d.wdata : 16'h0000;
      end
      ack_a_d = (state_d == HOLD) && !xact_d.port;
      ack_b_d = (state_d == HOLD) &&  xact_d.port;
      busy_d  = (state_d != IDLE);
      cap     = (state_q == STROBE) && (cnt_q == '0) && !xact_q.we;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         hpi_cs_n     <= 1'b1;
         hpi_r_n      <= 1'b1;
         hpi_w_n      <= 1'b1;
         hpi_address  <= 2'd0;
         hpi_data_out <= 16'h0000;
         a_ack        <= 1'b0;
         b_ack        <= 1'b0;
         a_rdata      <= 16'h0000;
         b_rdata      <= 16'h0000;
         busy         <= 1'b0;
      end else begin
         hpi_cs_n     <= cs_d;
         hpi_r_n      <= r_d;
         hpi_w_n      <= w_d;
         hpi_address  <= addr_d;
         hpi_data_out <= data_d;
         a_ack        <= ack_a_d;
         b_ack        <= ack_b_d;
         busy         <= busy_d;
         if (cap && !xact_q.port) a_rdata <= hpi_data_in;
         if (cap &&  xact_q.port) b_rdata <= hpi_data_in;
      end
   end

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// Directed bench for hpi_bus_sequencer: default-parameter instance plus a
// SETUP=2/STROBE=3/RECOVERY=1 instance, each with a small HPI read-latency model.
`timescale 1ns/1ps
module tb_hpi_bus_sequencer;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;

   logic [15:0] mem [4];

   // default instance
   logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
   logic [1:0]  a_addr = 0, b_addr = 0;
   logic [15:0] a_wdata = 0, b_wdata = 0;
   logic        a_ack, b_ack, busy, hpi_r_n, hpi_w_n, hpi_cs_n;
   logic [15:0] a_rdata, b_rdata, hpi_data_out;
   logic [15:0] hpi_data_in = 16'h0000;
   logic [1:0]  hpi_address;

   hpi_bus_sequencer dut (
      .Clk(Clk), .Reset(Reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .busy(busy), .hpi_address(hpi_address), .hpi_data_out(hpi_data_out),
      .hpi_data_in(hpi_data_in), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
      .hpi_cs_n(hpi_cs_n)
   );

   // alternate-timing instance
   logic        a_req2 = 0, a_we2 = 0, b_req2 = 0, b_we2 = 0;
   logic [1:0]  a_addr2 = 0, b_addr2 = 0;
   logic [15:0] a_wdata2 = 0, b_wdata2 = 0;
   logic        a_ack2, b_ack2, busy2, hpi_r_n2, hpi_w_n2, hpi_cs_n2;
   logic [15:0] a_rdata2, b_rdata2, hpi_data_out2;
   logic [15:0] hpi_data_in2 = 16'h0000;
   logic [1:0]  hpi_address2;

   hpi_bus_sequencer #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .RECOVERY_CYCLES(1)) dut2 (
      .Clk(Clk), .Reset(Reset),
      .a_req(a_req2), .a_we(a_we2), .a_addr(a_addr2), .a_wdata(a_wdata2),
      .a_ack(a_ack2), .a_rdata(a_rdata2),
      .b_req(b_req2), .b_we(b_we2), .b_addr(b_addr2), .b_wdata(b_wdata2),
      .b_ack(b_ack2), .b_rdata(b_rdata2),
      .busy(busy2), .hpi_address(hpi_address2), .hpi_data_out(hpi_data_out2),
      .hpi_data_in(hpi_data_in2), .hpi_r_n(hpi_r_n2), .hpi_w_n(hpi_w_n2),
      .hpi_cs_n(hpi_cs_n2)
   );

   // read data appears two cycles after hpi_r_n falls
   int rc = 0, rc2 = 0;
   always @(posedge Clk) begin
      if (!hpi_r_n) begin
         rc <= rc + 1;
         if (rc >= 1) hpi_data_in <= mem[hpi_address];
      end else begin
         rc <= 0;
         hpi_data_in <= 16'h0000;
      end
   end
   always @(posedge Clk) begin
      if (!hpi_r_n2) begin
         rc2 <= rc2 + 1;
         if (rc2 >= 1) hpi_data_in2 <= mem[hpi_address2];
      end else begin
         rc2 <= 0;
         hpi_data_in2 <= 16'h0000;
      end
   end

   task automatic test_reset();
      repeat (2) @(negedge Clk);
      checks++;
      if ({hpi_cs_n, hpi_r_n, hpi_w_n} !== 3'b111) begin
         failures++; $display("FAIL reset_strobes got=%b want=111", {hpi_cs_n, hpi_r_n, hpi_w_n});
      end
      checks++;
      if ({hpi_address, hpi_data_out, a_ack, b_ack, busy} !== 21'd0) begin
         failures++; $display("FAIL reset_outputs got addr=%0d data=%h acks=%b%b busy=%b want zeros",
                              hpi_address, hpi_data_out, a_ack, b_ack, busy);
      end
      checks++;
      if ({a_rdata, b_rdata} !== 32'd0) begin
         failures++; $display("FAIL reset_rdata got a=%h b=%h want 0", a_rdata, b_rdata);
      end
      Reset = 1'b1;
      @(negedge Clk);
      checks++;
      if (busy !== 1'b0 || busy2 !== 1'b0 || hpi_cs_n !== 1'b1) begin
         failures++; $display("FAIL reset_release got busy=%b busy2=%b cs_n=%b want 0 0 1", busy, busy2, hpi_cs_n);
      end
   endtask

   task automatic test_write_a();
      int cs_cnt, w_cnt, r_cnt, ack_cnt, ack_k, b_cnt;
      bit bad;
      cs_cnt = 0; w_cnt = 0; r_cnt = 0; ack_cnt = 0; ack_k = -1; b_cnt = 0; bad = 0;
      @(negedge Clk);
      a_req = 1; a_we = 1; a_addr = 2'd2; a_wdata = 16'h1234;
      for (int k = 1; k <= 12; k++) begin
         @(negedge Clk);
         if (!hpi_cs_n) cs_cnt++;
         if (!hpi_w_n) begin
            w_cnt++;
            if (hpi_data_out !== 16'h1234 || hpi_address !== 2'd2) bad = 1;
         end
         if (!hpi_r_n) r_cnt++;
         if (b_ack) b_cnt++;
         if (a_ack) begin ack_cnt++; ack_k = k; a_req = 0; end
      end
      checks++;
      if (cs_cnt != 6) begin failures++; $display("FAIL wr_cs_low got=%0d want=6", cs_cnt); end
      checks++;
      if (w_cnt != 4) begin failures++; $display("FAIL wr_w_low got=%0d want=4", w_cnt); end
      checks++;
      if (bad) begin failures++; $display("FAIL wr_addr_data got bad=1 want addr=2 data=1234 during strobe"); end
      checks++;
      if (r_cnt != 0) begin failures++; $display("FAIL wr_r_low got=%0d want=0", r_cnt); end
      checks++;
      if (ack_cnt != 1 || ack_k != 6) begin
         failures++; $display("FAIL wr_ack got count=%0d cycle=%0d want count=1 cycle=6", ack_cnt, ack_k);
      end
      checks++;
      if (b_cnt != 0 || busy !== 1'b0) begin
         failures++; $display("FAIL wr_idle got b_acks=%0d busy=%b want 0 0", b_cnt, busy);
      end
   endtask

   task automatic test_read_b();
      int w_cnt, r_cnt, ack_cnt, ack_k, a_cnt;
      bit bad;
      logic [15:0] rd_at_ack;
      w_cnt = 0; r_cnt = 0; ack_cnt = 0; ack_k = -1; a_cnt = 0; bad = 0; rd_at_ack = 16'hxxxx;
      @(negedge Clk);
      b_req = 1; b_we = 0; b_addr = 2'd0; b_wdata = 16'hFFFF;
      for (int k = 1; k <= 12; k++) begin
         @(negedge Clk);
         if (!hpi_w_n) w_cnt++;
         if (!hpi_r_n) begin
            r_cnt++;
            if (hpi_data_out !== 16'h0000 || hpi_address !== 2'd0) bad = 1;
         end
         if (a_ack) a_cnt++;
         if (b_ack) begin ack_cnt++; ack_k = k; rd_at_ack = b_rdata; b_req = 0; end
      end
      checks++;
      if (w_cnt != 0) begin failures++; $display("FAIL rd_w_low got=%0d want=0", w_cnt); end
      checks++;
      if (r_cnt != 4 || bad) begin
         failures++; $display("FAIL rd_r_low got=%0d bad=%0d want=4 bad=0", r_cnt, bad);
      end
      checks++;
      if (ack_cnt != 1 || ack_k != 6) begin
         failures++; $display("FAIL rd_ack got count=%0d cycle=%0d want 1 6", ack_cnt, ack_k);
      end
      checks++;
      if (rd_at_ack !== 16'hBEEF) begin failures++; $display("FAIL rd_data got=%h want=beef", rd_at_ack); end
      checks++;
      if (b_rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_data_hold got=%h want=beef", b_rdata); end
      checks++;
      if (a_rdata !== 16'h0000 || a_cnt != 0) begin
         failures++; $display("FAIL rd_a_untouched got rdata=%h acks=%0d want 0000 0", a_rdata, a_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int ack_k[$];
      bit ack_p[$];
      bit both_low;
      int want_k[4] = '{6, 15, 24, 33};
      bit want_p[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      bit b_data_bad;
      both_low = 0; b_data_bad = 0;
      @(negedge Clk);
      a_req = 1; a_we = 1; a_addr = 2'd1; a_wdata = 16'hAAAA;
      b_req = 1; b_we = 0; b_addr = 2'd3;
      for (int k = 1; k <= 40; k++) begin
         @(negedge Clk);
         if (!hpi_r_n && !hpi_w_n) both_low = 1;
         if (a_ack) begin ack_k.push_back(k); ack_p.push_back(1'b0); end
         if (b_ack) begin
            ack_k.push_back(k); ack_p.push_back(1'b1);
            if (b_rdata !== 16'h3333) b_data_bad = 1;
         end
         if (ack_k.size() >= 4) begin a_req = 0; b_req = 0; end
      end
      checks++;
      if (ack_k.size() != 4) begin
         failures++; $display("FAIL b2b_count got=%0d want=4", ack_k.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack_k[i] != want_k[i] || ack_p[i] != want_p[i]) begin
               failures++; $display("FAIL b2b_ack%0d got cycle=%0d port=%0d want cycle=%0d port=%0d",
                                    i, ack_k[i], ack_p[i], want_k[i], want_p[i]);
            end
         end
      end
      checks++;
      if (both_low || b_data_bad) begin
         failures++; $display("FAIL b2b_strobes_data got both_low=%0d bdata_bad=%0d want 0 0", both_low, b_data_bad);
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_drop_req();
      int ack_cnt, ack_k;
      bit busy_seen;
      ack_cnt = 0; ack_k = -1; busy_seen = 0;
      @(negedge Clk);
      a_req = 1; a_we = 1; a_addr = 2'd3; a_wdata = 16'h5A5A;
      for (int k = 1; k <= 14; k++) begin
         @(negedge Clk);
         if (k == 1) a_req = 0;
         if (a_ack) begin ack_cnt++; ack_k = k; end
         if (k >= 10 && busy) busy_seen = 1;
      end
      checks++;
      if (ack_cnt != 1 || ack_k != 6) begin
         failures++; $display("FAIL drop_ack got count=%0d cycle=%0d want 1 6", ack_cnt, ack_k);
      end
      checks++;
      if (busy_seen || hpi_cs_n !== 1'b1) begin
         failures++; $display("FAIL drop_idle got busy_seen=%0d cs_n=%b want 0 1", busy_seen, hpi_cs_n);
      end
   endtask

   task automatic test_reset_mid();
      int ack_cnt;
      bit busy_seen;
      ack_cnt = 0; busy_seen = 0;
      @(negedge Clk);
      a_req = 1; a_we = 1; a_addr = 2'd1; a_wdata = 16'h7777;
      repeat (3) @(negedge Clk);
      checks++;
      if (hpi_w_n !== 1'b0 || hpi_cs_n !== 1'b0) begin
         failures++; $display("FAIL rstmid_pre got w_n=%b cs_n=%b want 0 0", hpi_w_n, hpi_cs_n);
      end
      Reset = 1'b0;
      #1;
      checks++;
      if (hpi_w_n !== 1'b1 || hpi_cs_n !== 1'b1 || hpi_r_n !== 1'b1) begin
         failures++; $display("FAIL rstmid_async got w_n=%b cs_n=%b r_n=%b want 1 1 1", hpi_w_n, hpi_cs_n, hpi_r_n);
      end
      a_req = 0;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge Clk);
         if (a_ack || b_ack) ack_cnt++;
         if (busy) busy_seen = 1;
      end
      checks++;
      if (ack_cnt != 0 || busy_seen) begin
         failures++; $display("FAIL rstmid_after got acks=%0d busy_seen=%0d want 0 0", ack_cnt, busy_seen);
      end
      checks++;
      if (b_rdata !== 16'h0000) begin failures++; $display("FAIL rstmid_rdata got=%h want=0000", b_rdata); end
   endtask

   task automatic test_params();
      int w_cnt, r_cnt, ack1, ack2, acks;
      bit p1, p2;
      logic [15:0] rd;
      w_cnt = 0; r_cnt = 0; ack1 = -1; ack2 = -1; acks = 0; p1 = 0; p2 = 0; rd = 16'hxxxx;
      @(negedge Clk);
      a_req2 = 1; a_we2 = 1; a_addr2 = 2'd2; a_wdata2 = 16'h0F0F;
      b_req2 = 1; b_we2 = 0; b_addr2 = 2'd1;
      for (int k = 1; k <= 22; k++) begin
         @(negedge Clk);
         if (!hpi_w_n2) w_cnt++;
         if (!hpi_r_n2) r_cnt++;
         if (a_ack2 || b_ack2) begin
            acks++;
            if (acks == 1) begin ack1 = k; p1 = b_ack2; end
            if (acks == 2) begin ack2 = k; p2 = b_ack2; rd = b_rdata2; a_req2 = 0; b_req2 = 0; end
         end
      end
      checks++;
      if (w_cnt != 3 || r_cnt != 3) begin
         failures++; $display("FAIL par_strobe got w_low=%0d r_low=%0d want 3 3", w_cnt, r_cnt);
      end
      checks++;
      if (ack1 != 6 || p1 != 1'b0) begin
         failures++; $display("FAIL par_latency got cycle=%0d port=%0d want 6 0", ack1, p1);
      end
      checks++;
      if (ack2 - ack1 != 8 || p2 != 1'b1 || acks != 2) begin
         failures++; $display("FAIL par_period got period=%0d port=%0d acks=%0d want 8 1 2", ack2 - ack1, p2, acks);
      end
      checks++;
      if (rd !== 16'h1111) begin failures++; $display("FAIL par_rdata got=%h want=1111", rd); end
   endtask

   initial begin
      mem[0] = 16'hBEEF; mem[1] = 16'h1111; mem[2] = 16'h2222; mem[3] = 16'h3333;
      test_reset();
      test_write_a();
      test_read_b();
      test_back_to_back();
      test_drop_req();
      test_reset_mid();
      test_params();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end

endmodule
